capture_sequencer: RTL and testbench

- SysClk-domain controller that sequences one DataCaptureInitialFIFOs instance through a full capture.
- Arms capture through EnableDataCapture and waits for the FIFOs to report DataReady after FastTrigger.
- Drains exactly SAMPLE_WORDS 32-bit words with RdEn/DataValid and presents them on a valid/ready stream to the downstream transmit path.
- Provides abort, trigger timeout, and short-capture status.

---
 rtl/capture_sequencer.sv | 169 ++++++++++++++++
 tb/tb_capture_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Capture sequencer: arms the initial capture FIFOs, waits for a trigger,
// then drains SAMPLE_WORDS words onto a valid/ready stream.
module capture_sequencer #(
    parameter int SAMPLE_WORDS   = 256,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16,
    parameter int TMO_W          = 20
) (
    input  logic             SysClk,
    input  logic             Reset,
    input  logic             Arm,
    input  logic             Abort,
    input  logic             DataReady,
    input  logic             DataValid,
    input  logic [31:0]      s1DataOut,
    output logic             EnableDataCapture,
    output logic             RdEn,
    output logic [31:0]      OutData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             Busy,
    output logic             Done,
    output logic             Short,
    output logic             TimedOut,
    output logic [CNT_W-1:0] WordCount
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TRIG,
        READ,
        FLUSH,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(SAMPLE_WORDS);
    localparam logic [TMO_W-1:0] TMO_LAST  =
        TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             pending_q, pending_d;
    logic             short_q, short_d;
    logic             timed_out_q, timed_out_d;
    logic             rd_en;
    logic             xfer;
    logic             load;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        issued_d    = issued_q;
        tmo_d       = tmo_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        pending_d   = pending_q;
        short_d     = short_q;
        timed_out_d = 1'b0;
        rd_en       = 1'b0;
        xfer        = out_valid_q && OutReady;
        load        = DataValid && pending_q && !Abort;

        if (xfer) begin
            out_valid_d = 1'b0;
            if (word_cnt_q != '1) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
        // A word landing in the same cycle as a transfer refills the slot
        if (load) begin
            out_data_d  = s1DataOut;
            out_valid_d = 1'b1;
            pending_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (Arm && !Abort) begin
                    state_d    = WAIT_TRIG;
                    word_cnt_d = '0;
                    issued_d   = '0;
                    tmo_d      = '0;
                    short_d    = 1'b0;
                end
            end
            WAIT_TRIG: begin
                tmo_d = tmo_q + 1'b1;
                if (DataReady) begin
                    state_d = READ;
                end else if (TMO_EN && tmo_q == TMO_LAST) begin
                    state_d     = IDLE;
                    timed_out_d = 1'b1;
                end
            end
            READ: begin
                rd_en = !pending_q && (issued_q < LAST_WORD) && DataReady
                        && (!out_valid_q || OutReady) && !Abort;
                if (rd_en) begin
                    pending_d = 1'b1;
                    issued_d  = issued_q + 1'b1;
                end
                if (issued_q == LAST_WORD) begin
                    state_d = FLUSH;
                end else if (!DataReady) begin
                    short_d = 1'b1;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!pending_q && !out_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (Abort) begin
            state_d     = IDLE;
            pending_d   = 1'b0;
            out_valid_d = 1'b0;
            timed_out_d = 1'b0;
        end
    end

    always_ff @(posedge SysClk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            issued_q    <= '0;
            tmo_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            pending_q   <= 1'b0;
            short_q     <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            issued_q    <= issued_d;
            tmo_q       <= tmo_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            pending_q   <= pending_d;
            short_q     <= short_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign EnableDataCapture = (state_q == WAIT_TRIG);
    assign RdEn              = rd_en;
    assign OutData           = out_data_q;
    assign OutValid          = out_valid_q;
    assign Busy              = (state_q != IDLE);
    assign Done              = (state_q == DONE) && !Abort;
    assign Short             = short_q;
    assign TimedOut          = timed_out_q;
    assign WordCount         = word_cnt_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: a FIFO model answers each RdEn one cycle
// later and a scoreboard checks the delivered stream against base+n.
module tb_capture_sequencer;

    localparam int SW  = 8;
    localparam int TMO = 50;

    logic        SysClk    = 1'b0;
    logic        Reset     = 1'b0;
    logic        Arm       = 1'b0;
    logic        Abort     = 1'b0;
    logic        DataReady = 1'b0;
    logic        DataValid = 1'b0;
    logic [31:0] s1DataOut = '0;
    logic        OutReady  = 1'b0;
    logic        EnableDataCapture, RdEn, OutValid;
    logic        Busy, Done, Short, TimedOut;
    logic [31:0] OutData;
    logic [15:0] WordCount;

    capture_sequencer #(
        .SAMPLE_WORDS  (SW),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (16),
        .TMO_W         (8)
    ) dut (
        .SysClk           (SysClk),
        .Reset            (Reset),
        .Arm              (Arm),
        .Abort            (Abort),
        .DataReady        (DataReady),
        .DataValid        (DataValid),
        .s1DataOut        (s1DataOut),
        .EnableDataCapture(EnableDataCapture),
        .RdEn             (RdEn),
        .OutData          (OutData),
        .OutValid         (OutValid),
        .OutReady         (OutReady),
        .Busy             (Busy),
        .Done             (Done),
        .Short            (Short),
        .TimedOut         (TimedOut),
        .WordCount        (WordCount)
    );

    always #5 SysClk = ~SysClk;

    int          n_checks, n_pass, cyc_n;
    int          rden_cnt, done_cnt, tmo_cnt, gap_bad, stall_rd;
    int          unstable, both_bad, last_rd, fifo_idx, ready_mode;
    bit          rd_prev, extra_dv, dr, prev_stall;
    logic [31:0] base, pend_data, prev_data;
    logic        done_short;
    logic [15:0] done_wc;
    logic [31:0] rx[$];

    task automatic clear_stats();
        rden_cnt = 0; done_cnt = 0; tmo_cnt = 0; gap_bad = 0;
        stall_rd = 0; unstable = 0; both_bad = 0; last_rd = -100;
        fifo_idx = 0; prev_stall = 1'b0; done_short = 1'bx;
        done_wc = 'x; rx.delete();
    endtask

    // One clock cycle: drive inputs, sample outputs, advance to next negedge
    task automatic cyc();
        DataReady = dr;
        DataValid = rd_prev || extra_dv;
        s1DataOut = rd_prev ? pend_data : 32'hDEAD_BEEF;
        case (ready_mode)
            0:       OutReady = 1'b1;
            1:       OutReady = (cyc_n % 3 == 0);
            default: OutReady = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (prev_stall && (OutValid !== 1'b1 || OutData !== prev_data))
            unstable++;
        rd_prev = 1'b0;
        if (RdEn === 1'b1) begin
            rden_cnt++;
            if (cyc_n - last_rd < 2) gap_bad++;
            if (OutValid && !OutReady) stall_rd++;
            last_rd   = cyc_n;
            pend_data = base + 32'(fifo_idx);
            fifo_idx++;
            rd_prev   = 1'b1;
        end
        if (OutValid === 1'b1 && OutReady) rx.push_back(OutData);
        prev_stall = OutValid && !OutReady && !Abort && Reset;
        prev_data  = OutData;
        if (Done === 1'b1) begin
            done_cnt++;
            done_short = Short;
            done_wc    = WordCount;
        end
        if (TimedOut === 1'b1) tmo_cnt++;
        if (Done === 1'b1 && TimedOut === 1'b1) both_bad++;
        @(posedge SysClk);
        cyc_n++;
        @(negedge SysClk);
    endtask

    task automatic capture(input int delay, input int budget);
        int n;
        Arm = 1'b1; cyc(); Arm = 1'b0;
        repeat (delay) cyc();
        dr = 1'b1;
        n = 0;
        while (done_cnt == 0 && tmo_cnt == 0 && n < budget) begin
            cyc(); n++;
        end
        dr = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        Reset = 1'b0; cyc(); cyc(); Reset = 1'b1;
        n_checks++;
        if ({Busy, EnableDataCapture, RdEn, OutValid, Done, Short, TimedOut} !== 7'b0)
            $display("FAIL reset_flags: got %b want 0",
                {Busy, EnableDataCapture, RdEn, OutValid, Done, Short, TimedOut});
        else n_pass++;
        n_checks++;
        if (OutData !== 32'h0) $display("FAIL reset_data: got %h want 0", OutData);
        else n_pass++;
        n_checks++;
        if (WordCount !== 16'h0) $display("FAIL reset_wc: got %0d want 0", WordCount);
        else n_pass++;
    endtask

    task automatic test_normal();
        int n;
        clear_stats(); base = 32'h0001_0203; ready_mode = 0; dr = 1'b0;
        Arm = 1'b1; cyc(); Arm = 1'b0;
        n_checks++;
        if (EnableDataCapture !== 1'b1 || Busy !== 1'b1)
            $display("FAIL arm_enable: got en=%b busy=%b want 1 1", EnableDataCapture, Busy);
        else n_pass++;
        repeat (19) cyc();
        dr = 1'b1; cyc();
        n_checks++;
        if (EnableDataCapture !== 1'b0)
            $display("FAIL read_enable: got %b want 0", EnableDataCapture);
        else n_pass++;
        n = 0;
        while (done_cnt == 0 && n < 200) begin cyc(); n++; end
        dr = 1'b0;
        repeat (5) cyc();
        n_checks++;
        if (done_cnt !== 1) $display("FAIL normal_done: got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (rden_cnt !== SW) $display("FAIL normal_rden: got %0d want %0d", rden_cnt, SW);
        else n_pass++;
        n_checks++;
        if (gap_bad !== 0) $display("FAIL normal_gap: got %0d want 0", gap_bad);
        else n_pass++;
        n_checks++;
        if (rx.size() !== SW) $display("FAIL normal_count: got %0d want %0d", rx.size(), SW);
        else n_pass++;
        for (int i = 0; i < rx.size(); i++) begin
            n_checks++;
            if (rx[i] !== base + 32'(i))
                $display("FAIL normal_word%0d: got %h want %h", i, rx[i], base + 32'(i));
            else n_pass++;
        end
        n_checks++;
        if (done_wc !== 16'(SW) || done_short !== 1'b0)
            $display("FAIL normal_status: got wc=%0d short=%b want %0d 0", done_wc, done_short, SW);
        else n_pass++;
        n_checks++;
        if (WordCount !== 16'(SW) || Busy !== 1'b0)
            $display("FAIL normal_hold: got wc=%0d busy=%b want %0d 0", WordCount, Busy, SW);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        clear_stats(); base = $urandom; ready_mode = 1; dr = 1'b0;
        capture($urandom_range(1, 10), 400);
        n_checks++;
        if (done_cnt !== 1) $display("FAIL bp_done: got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (unstable !== 0) $display("FAIL bp_stable: got %0d want 0", unstable);
        else n_pass++;
        n_checks++;
        if (stall_rd !== 0) $display("FAIL bp_rd_stall: got %0d want 0", stall_rd);
        else n_pass++;
        n_checks++;
        if (rx.size() !== SW) $display("FAIL bp_count: got %0d want %0d", rx.size(), SW);
        else n_pass++;
        for (int i = 0; i < rx.size(); i++) begin
            n_checks++;
            if (rx[i] !== base + 32'(i))
                $display("FAIL bp_word%0d: got %h want %h", i, rx[i], base + 32'(i));
            else n_pass++;
        end
        n_checks++;
        if (done_wc !== 16'(SW)) $display("FAIL bp_wc: got %0d want %0d", done_wc, SW);
        else n_pass++;
        ready_mode = 0;
    endtask

    task automatic test_timeout();
        int  n;
        bit  prev_busy;
        clear_stats(); dr = 1'b0; ready_mode = 0;
        Arm = 1'b1; cyc(); Arm = 1'b0;
        n = 0; prev_busy = 1'b0;
        while (TimedOut !== 1'b1 && n < 200) begin
            prev_busy = Busy; cyc(); n++;
        end
        n_checks++;
        if (n !== TMO) $display("FAIL tmo_latency: got %0d want %0d", n, TMO);
        else n_pass++;
        n_checks++;
        if (Busy !== 1'b0 || prev_busy !== 1'b1)
            $display("FAIL tmo_busy: got busy=%b prev=%b want 0 1", Busy, prev_busy);
        else n_pass++;
        cyc();
        n_checks++;
        if (TimedOut !== 1'b0) $display("FAIL tmo_pulse: got %b want 0", TimedOut);
        else n_pass++;
        n_checks++;
        if (rden_cnt !== 0 || done_cnt !== 0 || tmo_cnt !== 1)
            $display("FAIL tmo_side: got rden=%0d done=%0d tmo=%0d want 0 0 1",
                rden_cnt, done_cnt, tmo_cnt);
        else n_pass++;
    endtask

    task automatic test_short();
        int n;
        clear_stats(); base = $urandom; ready_mode = 0; dr = 1'b1;
        Arm = 1'b1; cyc(); Arm = 1'b0;
        n = 0;
        while (rden_cnt < 5 && n < 100) begin cyc(); n++; end
        dr = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 100) begin cyc(); n++; end
        cyc();
        n_checks++;
        if (rden_cnt !== 5) $display("FAIL short_rden: got %0d want 5", rden_cnt);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || done_short !== 1'b1)
            $display("FAIL short_flag: got done=%0d short=%b want 1 1", done_cnt, done_short);
        else n_pass++;
        n_checks++;
        if (done_wc !== 16'd5) $display("FAIL short_wc: got %0d want 5", done_wc);
        else n_pass++;
        n_checks++;
        if (rx.size() !== 5) $display("FAIL short_count: got %0d want 5", rx.size());
        else n_pass++;
        for (int i = 0; i < rx.size(); i++) begin
            n_checks++;
            if (rx[i] !== base + 32'(i))
                $display("FAIL short_word%0d: got %h want %h", i, rx[i], base + 32'(i));
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        int n;
        clear_stats(); base = $urandom; ready_mode = 0; dr = 1'b1;
        Arm = 1'b1; cyc(); Arm = 1'b0;
        n = 0;
        while (rden_cnt < 3 && n < 100) begin cyc(); n++; end
        Abort = 1'b1; cyc(); Abort = 1'b0;
        n_checks++;
        if (Busy !== 1'b0 || OutValid !== 1'b0)
            $display("FAIL abort_idle: got busy=%b valid=%b want 0 0", Busy, OutValid);
        else n_pass++;
        extra_dv = 1'b1; cyc(); extra_dv = 1'b0;
        n_checks++;
        if (OutValid !== 1'b0) $display("FAIL abort_late_dv: got %b want 0", OutValid);
        else n_pass++;
        repeat (5) cyc();
        n_checks++;
        if (rx.size() !== 2 || done_cnt !== 0 || tmo_cnt !== 0)
            $display("FAIL abort_stream: got words=%0d done=%0d tmo=%0d want 2 0 0",
                rx.size(), done_cnt, tmo_cnt);
        else n_pass++;
        clear_stats(); base = $urandom; dr = 1'b0;
        capture(3, 200);
        n_checks++;
        if (done_cnt !== 1 || done_short !== 1'b0 || done_wc !== 16'(SW))
            $display("FAIL rearm_status: got done=%0d short=%b wc=%0d want 1 0 %0d",
                done_cnt, done_short, done_wc, SW);
        else n_pass++;
        n_checks++;
        if (rx.size() !== SW) $display("FAIL rearm_count: got %0d want %0d", rx.size(), SW);
        else n_pass++;
        for (int i = 0; i < rx.size(); i++) begin
            n_checks++;
            if (rx[i] !== base + 32'(i))
                $display("FAIL rearm_word%0d: got %h want %h", i, rx[i], base + 32'(i));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_stats(); base = $urandom; ready_mode = 0; dr = 1'b1;
        Arm = 1'b1; cyc(); Arm = 1'b0;
        n = 0;
        while (rden_cnt < 2 && n < 100) begin cyc(); n++; end
        Reset = 1'b0; cyc(); Reset = 1'b1;
        n_checks++;
        if ({Busy, EnableDataCapture, RdEn, OutValid, Done, Short, TimedOut} !== 7'b0
            || WordCount !== 16'h0 || OutData !== 32'h0)
            $display("FAIL midreset_out: got flags=%b wc=%0d data=%h want 0",
                {Busy, EnableDataCapture, RdEn, OutValid, Done, Short, TimedOut},
                WordCount, OutData);
        else n_pass++;
        dr = 1'b0;
        cyc();
        n_checks++;
        if (OutValid !== 1'b0) $display("FAIL midreset_dv: got %b want 0", OutValid);
        else n_pass++;
        Arm = 1'b1; cyc(); Arm = 1'b0;
        repeat (10) cyc();
        Arm = 1'b1; cyc(); Arm = 1'b0;
        n = 11;
        while (TimedOut !== 1'b1 && n < 200) begin cyc(); n++; end
        n_checks++;
        if (n !== TMO) $display("FAIL arm_busy_ignored: got %0d want %0d", n, TMO);
        else n_pass++;
        Arm = 1'b1; Abort = 1'b1; cyc(); Arm = 1'b0; Abort = 1'b0;
        n_checks++;
        if (Busy !== 1'b0 || EnableDataCapture !== 1'b0)
            $display("FAIL arm_abort: got busy=%b en=%b want 0 0", Busy, EnableDataCapture);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            clear_stats(); base = $urandom; ready_mode = 2; dr = 1'b0;
            capture($urandom_range(0, 30), 600);
            n_checks++;
            if (done_cnt !== 1 || done_short !== 1'b0 || done_wc !== 16'(SW))
                $display("FAIL rnd%0d_status: got done=%0d short=%b wc=%0d want 1 0 %0d",
                    k, done_cnt, done_short, done_wc, SW);
            else n_pass++;
            n_checks++;
            if (unstable !== 0 || stall_rd !== 0 || gap_bad !== 0 || both_bad !== 0)
                $display("FAIL rnd%0d_proto: got %0d %0d %0d %0d want 0 0 0 0",
                    k, unstable, stall_rd, gap_bad, both_bad);
            else n_pass++;
            n_checks++;
            if (rx.size() !== SW)
                $display("FAIL rnd%0d_count: got %0d want %0d", k, rx.size(), SW);
            else n_pass++;
            for (int i = 0; i < rx.size(); i++) begin
                n_checks++;
                if (rx[i] !== base + 32'(i))
                    $display("FAIL rnd%0d_word%0d: got %h want %h",
                        k, i, rx[i], base + 32'(i));
                else n_pass++;
            end
        end
        ready_mode = 0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc_n = 0;
        rd_prev = 1'b0; extra_dv = 1'b0; dr = 1'b0;
        ready_mode = 0; base = '0; pend_data = '0; prev_data = '0;
        clear_stats();
        @(negedge SysClk);
        test_reset();
        test_normal();
        test_backpressure();
        test_timeout();
        test_short();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
